// File: rtl/md_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : md_sched_if
// Purpose  : Groups the E-stage issue signals and the HI/LO/busy/stall results
//            of the multiply/divide scheduler. Clock and reset are not part of
//            the interface and stay plain ports on the scheduler.
// Signals  : start, op[2:0], A[31:0], B[31:0], Req, md_use_D  (issue side)
//            busy, stall_md, hi[31:0], lo[31:0]               (scheduler side)
// Modports : master - drives issue signals (pipeline / testbench)
//            slave  - the md_sched block
// Revision : 1.0 - initial release
// ============================================================================
interface md_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, A, B, Req, md_use_D,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, A, B, Req, md_use_D,
        output busy, stall_md, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module   : md_sched
// Purpose  : Multiply/divide scheduler. Owns the architectural HI/LO registers,
//            sequences multi-cycle MULT/MULTU/DIV/DIVU (and optional MADD/MSUB)
//            operations issued from E stage, and raises busy/stall toward the
//            hazard unit. An op flushed by Req in its issue cycle never starts.
// Ports    : clk            rising-edge clock
//            reset          asynchronous, active-low
//            md (slave)     start, op, A, B, Req, md_use_D in;
//                           busy, stall_md, hi, lo out
// Params   : MULT_CYCLES    busy duration of multiplies (>= 1)
//            DIV_CYCLES     busy duration of divides    (>= 1)
// Config   : MD_MADD_EN     when defined, op 6 = MADD and op 7 = MSUB; when
//                           undefined, op 6/7 are illegal and ignored
// Revision : 1.0 - initial release
// ============================================================================
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    md_sched_if.slave md
);

    localparam int c_MAX   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W = $clog2(c_MAX + 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
    localparam logic [2:0] c_OP_MADD  = 3'd6;
    localparam logic [2:0] c_OP_MSUB  = 3'd7;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [2:0]         r_op;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_is_multi;
    logic               w_is_mul;
    logic               w_accept;
    logic               w_launch;
    logic               w_done;

    // ------------------------------------------------------------------
    // Issue decode
    // ------------------------------------------------------------------
`ifdef MD_MADD_EN
    assign w_is_multi = (md.op <= c_OP_DIVU) || (md.op == c_OP_MADD) || (md.op == c_OP_MSUB);
`else
    assign w_is_multi = (md.op <= c_OP_DIVU);
`endif
    assign w_is_mul = (md.op == c_OP_MULT) || (md.op == c_OP_MULTU) ||
                      (md.op == c_OP_MADD) || (md.op == c_OP_MSUB);

    // Req flushes the E-stage op in its issue cycle only; a start that arrives
    // while an op is running is dropped (the hazard unit is already stalling).
    assign w_accept = md.start && !md.Req && (r_state == c_IDLE);
    assign w_launch = w_accept && w_is_multi;
    assign w_done   = (r_state == c_RUN) && (r_cnt == c_CNT_W'(1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_launch) w_state_nxt = c_RUN;
            c_RUN:   if (w_done)   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands, evaluated for the completion edge
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_div_s;
    logic [31:0] w_div_u;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;
    logic [63:0] w_res;
    logic        w_res_we;

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide done on magnitudes so the quotient truncates toward zero
    // and the remainder takes the dividend's sign. 0x80000000 / -1 falls out
    // naturally: magnitude 2^31, negated, wraps back to 0x80000000 with rem 0.
    assign w_a_mag = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_b_mag = r_b[31] ? (32'd0 - r_b) : r_b;
    // Divisors forced to 1 on zero only to keep the divider defined; the
    // result is not written in that case.
    assign w_div_s = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_div_u = (r_b == 32'd0) ? 32'd1 : r_b;
    assign w_q_mag = w_a_mag / w_div_s;
    assign w_r_mag = w_a_mag % w_div_s;
    assign w_quo_s = (r_a[31] ^ r_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem_s = r_a[31] ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_quo_u = r_a / w_div_u;
    assign w_rem_u = r_a % w_div_u;

    always_comb begin
        w_res    = {r_hi, r_lo};
        w_res_we = 1'b0;
        case (r_op)
            c_OP_MULT: begin
                w_res    = w_prod_s;
                w_res_we = 1'b1;
            end
            c_OP_MULTU: begin
                w_res    = w_prod_u;
                w_res_we = 1'b1;
            end
            c_OP_DIV: begin
                w_res    = {w_rem_s, w_quo_s};
                w_res_we = (r_b != 32'd0);
            end
            c_OP_DIVU: begin
                w_res    = {w_rem_u, w_quo_u};
                w_res_we = (r_b != 32'd0);
            end
`ifdef MD_MADD_EN
            // Accumulator is HI/LO as they stand at the completion edge.
            c_OP_MADD: begin
                w_res    = {r_hi, r_lo} + w_prod_s;
                w_res_we = 1'b1;
            end
            c_OP_MSUB: begin
                w_res    = {r_hi, r_lo} - w_prod_s;
                w_res_we = 1'b1;
            end
`endif
            default: begin
                w_res    = {r_hi, r_lo};
                w_res_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, countdown and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_launch) begin
                r_a   <= md.A;
                r_b   <= md.B;
                r_op  <= md.op;
                r_cnt <= w_is_mul ? c_CNT_W'(MULT_CYCLES) : c_CNT_W'(DIV_CYCLES);
            end else if (r_state == c_RUN) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end

            if (w_accept && (md.op == c_OP_MTHI)) begin
                r_hi <= md.A;
            end
            if (w_accept && (md.op == c_OP_MTLO)) begin
                r_lo <= md.A;
            end
            if (w_done && w_res_we) begin
                r_hi <= w_res[63:32];
                r_lo <= w_res[31:0];
            end
        end
    end

    assign md.busy     = (r_state == c_RUN);
    assign md.stall_md = md.md_use_D && ((r_state == c_RUN) || (md.start && w_is_multi));
    assign md.hi       = r_hi;
    assign md.lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sched
// Purpose  : Directed self-checking bench for md_sched. Inputs change and
//            outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sched;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n;

    md_sched_if u_if ();

    md_sched #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the issue edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req);
        u_if.start = 1'b1;
        u_if.op    = op;
        u_if.A     = a;
        u_if.B     = b;
        u_if.Req   = req;
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.Req   = 1'b0;
    endtask

    // Counts falling edges on which busy is still high (bounded).
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (u_if.busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        u_if.start    = 1'b0;
        u_if.op       = 3'd0;
        u_if.A        = 32'd0;
        u_if.B        = 32'd0;
        u_if.Req      = 1'b0;
        u_if.md_use_D = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, u_if.busy}, 32'd0);
        check("rst_hi", u_if.hi, 32'd0);
        check("rst_lo", u_if.lo, 32'd0);
        check("rst_stall", {31'd0, u_if.stall_md}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // MTHI / MTLO are single-cycle
        issue(3'd4, 32'h0000_0055, 32'd0, 1'b0);
        check("mthi_busy", {31'd0, u_if.busy}, 32'd0);
        issue(3'd5, 32'h0000_0066, 32'd0, 1'b0);
        check("mthi_hi", u_if.hi, 32'h0000_0055);
        check("mtlo_lo", u_if.lo, 32'h0000_0066);

        // Asynchronous reset in the middle of a DIV
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        check("div_busy_on", {31'd0, u_if.busy}, 32'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, u_if.busy}, 32'd0);
        check("arst_hi", u_if.hi, 32'd0);
        check("arst_lo", u_if.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, 1'b0);
        wait_busy(n);
        check("post_rst_cycles", n, 32'd5);
        check("post_rst_lo", u_if.lo, 32'd12);
        check("post_rst_hi", u_if.hi, 32'd0);

        // MULT signed: -1 * 2
        issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_busy(n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", u_if.hi, 32'hFFFF_FFFF);
        check("mult_lo", u_if.lo, 32'hFFFF_FFFE);

        // MULTU: 0xFFFFFFFF * 2
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_busy(n);
        check("multu_hi", u_if.hi, 32'h0000_0001);
        check("multu_lo", u_if.lo, 32'hFFFF_FFFE);

        // DIV -7 / 2 -> q -3, r -1
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_busy(n);
        check("div_cycles", n, 32'd10);
        check("div_lo", u_if.lo, 32'hFFFF_FFFD);
        check("div_hi", u_if.hi, 32'hFFFF_FFFF);

        // DIVU 0xFFFFFFFF / 16
        issue(3'd3, 32'hFFFF_FFFF, 32'd16, 1'b0);
        wait_busy(n);
        check("divu_lo", u_if.lo, 32'h0FFF_FFFF);
        check("divu_hi", u_if.hi, 32'h0000_000F);

        // DIV overflow 0x80000000 / -1
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_busy(n);
        check("divovf_lo", u_if.lo, 32'h8000_0000);
        check("divovf_hi", u_if.hi, 32'd0);

        // DIVU by zero after MTHI: full duration, HI/LO untouched
        issue(3'd4, 32'h0000_1234, 32'd0, 1'b0);
        issue(3'd3, 32'd5, 32'd0, 1'b0);
        wait_busy(n);
        check("div0_cycles", n, 32'd10);
        check("div0_hi", u_if.hi, 32'h0000_1234);
        check("div0_lo", u_if.lo, 32'h8000_0000);

        // Req in the issue cycle blocks the op
        issue(3'd0, 32'd7, 32'd7, 1'b1);
        check("req_busy", {31'd0, u_if.busy}, 32'd0);
        @(negedge clk);
        check("req_hi", u_if.hi, 32'h0000_1234);
        check("req_lo", u_if.lo, 32'h8000_0000);

        // Req during RUN does not disturb the running op
        issue(3'd1, 32'd3, 32'd5, 1'b0);
        u_if.Req = 1'b1;
        @(negedge clk);
        u_if.Req = 1'b0;
        wait_busy(n);
        check("reqrun_cycles", n, 32'd4);
        check("reqrun_lo", u_if.lo, 32'd15);
        check("reqrun_hi", u_if.hi, 32'd0);

        // stall_md: combinational in the issue cycle, then for the busy period
        u_if.md_use_D = 1'b1;
        u_if.start    = 1'b1;
        u_if.op       = 3'd0;
        u_if.A        = 32'd2;
        u_if.B        = 32'd3;
        #1;
        check("stall_issue", {31'd0, u_if.stall_md}, 32'd1);
        @(negedge clk);
        u_if.start = 1'b0;
        n = 0;
        while (u_if.stall_md && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", n, 32'd5);
        check("stall_busy_off", {31'd0, u_if.busy}, 32'd0);
        check("stall_lo", u_if.lo, 32'd6);
        u_if.md_use_D = 1'b0;

        // start while busy is ignored
        issue(3'd0, 32'd1, 32'd1, 1'b0);
        issue(3'd5, 32'h0000_DEAD, 32'd0, 1'b0);
        wait_busy(n);
        check("ignbusy_lo", u_if.lo, 32'd1);
        check("ignbusy_hi", u_if.hi, 32'd0);

        // Op 6: MADD when enabled, illegal otherwise
        issue(3'd4, 32'd0, 32'd0, 1'b0);
        issue(3'd5, 32'd5, 32'd0, 1'b0);
        u_if.md_use_D = 1'b1;
        u_if.start    = 1'b1;
        u_if.op       = 3'd6;
        u_if.A        = 32'd3;
        u_if.B        = 32'd4;
        #1;
`ifdef MD_MADD_EN
        check("madd_stall", {31'd0, u_if.stall_md}, 32'd1);
        @(negedge clk);
        u_if.start    = 1'b0;
        u_if.md_use_D = 1'b0;
        wait_busy(n);
        check("madd_cycles", n, 32'd5);
        check("madd_lo", u_if.lo, 32'd17);
        check("madd_hi", u_if.hi, 32'd0);
`else
        check("op6_stall", {31'd0, u_if.stall_md}, 32'd0);
        @(negedge clk);
        u_if.start    = 1'b0;
        u_if.md_use_D = 1'b0;
        check("op6_busy", {31'd0, u_if.busy}, 32'd0);
        @(negedge clk);
        check("op6_lo", u_if.lo, 32'd5);
        check("op6_hi", u_if.hi, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
